// File: rtl/keccak_digest_squeezer_if.sv
// Handshake bundle for keccak_digest_squeezer: permuted-state capture side and
// 64-bit lane stream side. The squeezer connects through the slave modport.
interface keccak_digest_squeezer_if;
   logic [1599:0] state_in;
   logic          state_valid;
   logic          state_ready;
   logic [63:0]   out;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;

   modport master (
      output state_in, state_valid, out_ready,
      input  state_ready, out, out_valid, out_last, busy
   );

   modport slave (
      input  state_in, state_valid, out_ready,
      output state_ready, out, out_valid, out_last, busy
   );
endinterface

// File: rtl/keccak_digest_squeezer.sv
// Captures one permuted Keccak state and streams its first OUT_LANES lanes as 64-bit words.
// Optional build macro KECCAK_SQUEEZE_BYTE_SWAP_EN byte-reverses every emitted lane.
module keccak_digest_squeezer #(
   parameter int OUT_LANES = 8,
   parameter int CNT_W     = 5
) (
   input  logic                    clk,
   input  logic                    reset_n,
   keccak_digest_squeezer_if.slave sq
);

   typedef enum logic {IDLE, EMIT} state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_LANES - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
   logic [63:0]      shadow_reg  [OUT_LANES];
   logic [63:0]      shadow_next [OUT_LANES];
   logic [63:0]      cap_lane    [OUT_LANES];
   logic [63:0]      lane_sel;
   logic [63:0]      out_reg, out_next;
   logic             out_valid_reg, out_valid_next;
   logic             out_last_reg, out_last_next;
   logic             busy_reg, busy_next;
   logic             state_ready_w;
   logic             capture;

   // Lane 0 sits in the most significant 64 bits of the state vector.
   for (genvar gi = 0; gi < OUT_LANES; gi++) begin : g_lane
      assign cap_lane[gi] = sq.state_in[1599-64*gi -: 64];
   end

   function automatic logic [63:0] fmt_lane(input logic [63:0] lane);
`ifdef KECCAK_SQUEEZE_BYTE_SWAP_EN
      logic [63:0] r;
      for (int b = 0; b < 8; b++) begin
         r[8*b +: 8] = lane[56-8*b +: 8];
      end
      return r;
`else
      return lane;
`endif
   endfunction

   // Accepting on the final handshake lets a held-valid upstream stream back to back.
   assign state_ready_w = (state_reg == IDLE) ||
                          ((state_reg == EMIT) && sq.out_ready && out_last_reg);
   assign capture       = sq.state_valid && state_ready_w;

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      shadow_next = shadow_reg;
      out_next    = out_reg;
      cnt_inc     = cnt_reg + 1'b1;
      lane_sel    = '0;
      for (int i = 0; i < OUT_LANES; i++) begin
         if (cnt_inc == CNT_W'(i)) begin
            lane_sel = shadow_reg[i];
         end
      end

      if (capture) begin
         state_next  = EMIT;
         cnt_next    = '0;
         shadow_next = cap_lane;
         out_next    = fmt_lane(cap_lane[0]);
      end else if ((state_reg == EMIT) && sq.out_ready) begin
         if (out_last_reg) begin
            state_next = IDLE;
         end else begin
            cnt_next = cnt_inc;
            out_next = fmt_lane(lane_sel);
         end
      end

      out_valid_next = (state_next == EMIT);
      busy_next      = (state_next == EMIT);
      out_last_next  = (state_next == EMIT) && (cnt_next == LAST_IDX);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         shadow_reg    <= '{default: '0};
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         shadow_reg    <= shadow_next;
         out_reg       <= out_next;
         out_valid_reg <= out_valid_next;
         out_last_reg  <= out_last_next;
         busy_reg      <= busy_next;
      end
   end

   assign sq.state_ready = state_ready_w;
   assign sq.out         = out_reg;
   assign sq.out_valid   = out_valid_reg;
   assign sq.out_last    = out_last_reg;
   assign sq.busy        = busy_reg;

endmodule

// File: doc/keccak_digest_squeezer.md
Name: keccak_digest_squeezer

Overview:
- Output-side reader for the Keccak state that the permutation rounds produce.
- Captures one 1600-bit permuted state and streams its first OUT_LANES lanes as 64-bit words over a valid/ready interface.
- Sits between the f-permutation output and the digest consumer.
- Lane i (i = 5y+x) occupies state bits [1599-64i : 1536-64i], the same lane map the round logic uses.

Parameters:
- OUT_LANES, 8, number of lanes emitted per captured state; legal range 1..25 (8 = SHA3-512, 4 = SHA3-256).
- CNT_W, 5, width of the lane counter; must satisfy 2^CNT_W > OUT_LANES.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- state_in  input  1600  permuted state; lane i at [1599-64i : 1536-64i].
- state_valid  input  1  state_in is valid.
- state_ready  output  1  block can capture a state this cycle.
- out  output  64  current lane word.
- out_valid  output  1  out holds a valid lane.
- out_ready  input  1  consumer accepts out this cycle.
- out_last  output  1  out is lane OUT_LANES-1.
- busy  output  1  a capture is being streamed.

Behaviour:
- Reset: asynchronous, takes effect while reset_n=0 regardless of clk.
  - FSM goes to IDLE; counter = 0; shadow register cleared to 0.
  - out_valid=0, out_last=0, busy=0, out=64'h0.
- Reset asserted mid-stream discards the remaining lanes; no partial output follows reset release.
- FSM states and transitions:
  - IDLE: state_ready=1. When state_valid=1, capture lanes 0..OUT_LANES-1 of state_in into the shadow register, set counter=0, go to EMIT. Other lanes are ignored.
  - EMIT: out_valid=1 and out = shadow lane[counter]; busy=1; out_last = (counter == OUT_LANES-1).
    - On out_valid && out_ready && !out_last: counter increments by 1.
    - On out_valid && out_ready && out_last: if state_valid is also 1, capture the new state, reset counter=0 and stay in EMIT. Otherwise go to IDLE.
- state_ready = IDLE || (EMIT && out_ready && out_last). This allows back-to-back captures with no bubble.
- Latency: the first lane appears with out_valid=1 in the cycle after the capture edge. Each lane lasts at least one cycle. Minimum stream length is OUT_LANES cycles.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out, out_last and the counter hold stable.
  - out_valid never drops before its transfer completes.
  - state_valid while state_ready=0 is ignored; the upstream side must hold the state until state_ready=1.
- The counter never exceeds OUT_LANES-1; there is no wrap beyond it.
- OUT_LANES=1: every lane is the last lane; out_last=1 whenever out_valid=1.
- Registered outputs: out, out_valid, out_last, busy. state_ready is combinational from the FSM state, out_ready and out_last.

Optional Feature:
- Macro: KECCAK_SQUEEZE_BYTE_SWAP_EN.
- Defined: each emitted lane is byte-reversed (out[63:56] = lane[7:0], ..., out[7:0] = lane[63:56]). This gives byte-serial digest order directly.
- Undefined: lane emitted bit-for-bit as stored (out = lane[63:0]).
- Handshake and timing are identical in both builds.

Test Plan:
- Reset, then state_in lanes = 64'h0000_0000_0000_00i0 for i=0..24, state_valid pulse, out_ready=1 -> 8 words 64'h00,64'h10,...,64'h70 on consecutive cycles; out_last only on 64'h70; then IDLE with state_ready=1.
- Same capture with out_ready toggling 1,0,0,1,... -> out stable while out_ready=0; same 8 words in order; no duplicates or drops.
- Two states (lane0 = 64'hAAAA..., lane0 = 64'h5555...) with state_valid held high -> second captured on the first stream's last handshake; lane 0 of the second appears the very next cycle; 16 contiguous words.
- reset_n low on the 4th lane of a stream, asynchronously between clock edges -> out_valid=0 immediately; after release state_ready=1 and no stale lanes appear.
- OUT_LANES=4, lane0=64'h0123456789ABCDEF, macro defined -> first word 64'hEFCDAB8967452301; without macro 64'h0123456789ABCDEF; out_last on the 4th word.
- state_valid pulsed during EMIT with out_ready=0 -> capture ignored; the current stream completes unchanged.
